ex_muldiv: RTL and testbench
============================

Name: ex_muldiv

Overview:
- Iterative RV32M multiply/divide unit in the execute stage.
- Sits directly downstream of the ID/EX pipeline register and consumes its registered inst/op1/op2/rd outputs.
- While computing, it raises a hold request to the pipeline control block. ID/EX and earlier stages then freeze, and the M-instruction stays stable on the inputs.
- Result is returned to the execute-stage writeback mux with a one-cycle valid.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported and verified.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- inst_i  in  32  instruction from ID/EX.
- op1_i  in  32  rs1 value (dividend / multiplicand).
- op2_i  in  32  rs2 value (divisor / multiplier).
- rd_addr_i  in  5  destination register from ID/EX.
- flush_i  in  1  abort request from control.
- hold_flag_o  out  1  stall request to control.
- result_o  out  32  computed result.
- result_valid_o  out  1  result_o/rd_addr_o valid this cycle.
- rd_addr_o  out  5  destination of the completed op.
- reg_wen_o  out  1  register write enable for the completed op.

Behaviour:
- Decode:
  - M-op when opcode=0110011 and funct7=0000001.
  - funct3 selects: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
  - Any other instruction is ignored.
- States: IDLE, CALC, DONE. Reset and flush force IDLE.
- Reset: on rst=1 at a clock edge, the next cycle is IDLE, the counter is cleared, and all registered outputs are 0.
  - hold_flag_o is 0 whenever the state is IDLE and no start is present.
  - Reset mid-CALC discards the operation with no valid pulse.
- IDLE, M-op present (start):
  - hold_flag_o=1 combinationally in the same cycle.
  - At the clock edge, latch funct3, rd_addr_i, the operand magnitudes, and the result-sign flags.
  - Signedness: MULH/DIV/REM treat both operands as signed; MULHSU treats op1 as signed; MUL/MULHU/DIVU/REMU treat both as unsigned.
  - Clear the 5-bit counter and go to CALC.
- IDLE, special-case divide (goes to DONE next cycle, skipping CALC):
  - Divisor==0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give op1.
  - Signed overflow (DIV/REM with op1=0x80000000, op2=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- CALC:
  - One iteration per cycle: shift-add multiply (64-bit accumulator) or restoring divide (quotient/remainder shift).
  - After 32 iterations (counter 31 at the edge) go to DONE.
  - hold_flag_o=1 throughout.
- DONE:
  - hold_flag_o=0, result_valid_o=1, reg_wen_o=1, rd_addr_o = latched rd.
  - result_o is registered and stays stable for the cycle.
  - Sign fix-up: negate the 64-bit product if its sign flag is set.
    - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
  - Divide fix-up:
    - Quotient is negated if sign(op1)^sign(op2) for DIV.
    - Remainder is negated if sign(op1) for REM.
  - Always returns to IDLE next cycle. The same instruction is not restarted because ID/EX advances on that edge.
- Latency:
  - Normal op: start at T0; hold high T0..T32 (33 cycles); valid at T33.
  - Special case: hold high T0 only; valid at T1.
- Outside DONE: result_valid_o=0, reg_wen_o=0, result_o=0, rd_addr_o=0.
- Flush:
  - flush_i=1 in any state: next state IDLE, no valid pulse.
  - hold_flag_o is forced 0 in the flush cycle.
  - Flush together with start: flush wins, no op is latched.
- Back-to-back M-ops: a new start is accepted in the IDLE cycle immediately after DONE.

Test Plan:
- MUL op1=7, op2=0xFFFFFFFD -> hold high T0..T32; at T33 result_o=0xFFFFFFEB, valid=1, rd echoed, hold=0.
- op1=op2=0xFFFFFFFF: MULHU -> 0xFFFFFFFE; MULH -> 0x00000000; MULHSU -> 0xFFFFFFFF; MUL -> 0x00000001.
- DIV -7/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, valid at T1 with one hold cycle; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- rst=1 at CALC iteration 10 -> next cycle IDLE, hold=0, no valid pulse ever; flush_i at iteration 5 -> same result.
- Non-M inputs (ADD 0x00208033, NOP 0x00000013) -> hold_flag_o never asserted; two DIVU ops back-to-back -> two valid pulses 34 cycles apart.

Source files
------------

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Holds the pipeline while iterating; one iteration per cycle, 32 iterations per op.
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            hold_flag_o,
  output logic [XLEN-1:0] result_o,
  output logic            result_valid_o,
  output logic [4:0]      rd_addr_o,
  output logic            reg_wen_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] opnd_q, opnd_d;
  logic [63:0] acc_q, acc_d;
  logic        neg_q, neg_d;
  logic [31:0] result_q, result_d;
  logic        valid_q, valid_d;
  logic [4:0]  rd_out_q, rd_out_d;

  logic        is_mop, op1_signed, op2_signed, s1, s2, div_zero, div_ovf, hold_flag;
  logic [2:0]  f3;
  logic [31:0] mag1, mag2, quo_fix, rem_fix, final_res;
  logic [32:0] mul_sum, div_trial, div_diff;
  logic [63:0] acc_step, prod_fix;
  logic        unused_inst_bits;

  assign unused_inst_bits = ^{inst_i[24:15], inst_i[11:7]};

  assign f3         = inst_i[14:12];
  assign is_mop     = (inst_i[6:0] == 7'b0110011) && (inst_i[31:25] == 7'b0000001);
  assign op1_signed = (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b100) || (f3 == 3'b110);
  assign op2_signed = (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b110);
  assign s1         = op1_signed & op1_i[31];
  assign s2         = op2_signed & op2_i[31];
  assign mag1       = s1 ? -op1_i : op1_i;
  assign mag2       = s2 ? -op2_i : op2_i;
  assign div_zero   = f3[2] && (op2_i == 32'd0);
  assign div_ovf    = f3[2] && !f3[0] && (op1_i == 32'h8000_0000) && (op2_i == 32'hFFFF_FFFF);

  // acc_q holds {hi, multiplier} for multiply and {remainder, quotient} for divide.
  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    div_trial = {acc_q[63:32], acc_q[31]};
    div_diff  = div_trial - {1'b0, opnd_q};
    if (funct3_q[2]) begin
      if (!div_diff[32]) acc_step = {div_diff[31:0], acc_q[30:0], 1'b1};
      else               acc_step = {div_trial[31:0], acc_q[30:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc_q[31:1]};
    end
    prod_fix = neg_q ? -acc_step : acc_step;
    quo_fix  = neg_q ? -acc_step[31:0] : acc_step[31:0];
    rem_fix  = neg_q ? -acc_step[63:32] : acc_step[63:32];
    case (funct3_q)
      3'b000:                 final_res = prod_fix[31:0];
      3'b001, 3'b010, 3'b011: final_res = prod_fix[63:32];
      3'b100, 3'b101:         final_res = quo_fix;
      default:                final_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    funct3_d  = funct3_q;
    rd_d      = rd_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    result_d  = '0;
    valid_d   = 1'b0;
    rd_out_d  = '0;
    hold_flag = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_mop) begin
          hold_flag = 1'b1;
          if (div_zero) begin
            state_d  = DONE;
            result_d = f3[1] ? op1_i : 32'hFFFF_FFFF;
            valid_d  = 1'b1;
            rd_out_d = rd_addr_i;
          end else if (div_ovf) begin
            state_d  = DONE;
            result_d = f3[1] ? 32'd0 : 32'h8000_0000;
            valid_d  = 1'b1;
            rd_out_d = rd_addr_i;
          end else begin
            state_d  = CALC;
            cnt_d    = '0;
            funct3_d = f3;
            rd_d     = rd_addr_i;
            // Remainder sign follows the dividend only; everything else is the xor.
            neg_d    = (f3[2] && f3[1]) ? s1 : (s1 ^ s2);
            opnd_d   = f3[2] ? mag2 : mag1;
            acc_d    = {32'd0, (f3[2] ? mag1 : mag2)};
          end
        end
      end
      CALC: begin
        hold_flag = 1'b1;
        acc_d     = acc_step;
        cnt_d     = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d  = DONE;
          result_d = final_res;
          valid_d  = 1'b1;
          rd_out_d = rd_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d   = IDLE;
      hold_flag = 1'b0;
      result_d  = '0;
      valid_d   = 1'b0;
      rd_out_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      funct3_q <= '0;
      rd_q     <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      funct3_q <= funct3_d;
      rd_q     <= rd_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      rd_out_q <= rd_out_d;
    end
  end

  assign hold_flag_o    = hold_flag;
  assign result_o       = result_q;
  assign result_valid_o = valid_q;
  assign rd_addr_o      = rd_out_q;
  assign reg_wen_o      = valid_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed RV32M cases plus random ops
// compared against an arithmetic reference model.
module tb_ex_muldiv;

  localparam int CLK_PERIOD = 10;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] ADD_INST = 32'h0020_8033;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i, op1_i, op2_i;
  logic [4:0]  rd_addr_i;
  logic        flush_i;
  logic        hold_flag_o;
  logic [31:0] result_o;
  logic        result_valid_o;
  logic [4:0]  rd_addr_o;
  logic        reg_wen_o;

  int nCmp = 0;
  int nErr = 0;

  ex_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .inst_i(inst_i), .op1_i(op1_i), .op2_i(op2_i),
    .rd_addr_i(rd_addr_i), .flush_i(flush_i), .hold_flag_o(hold_flag_o),
    .result_o(result_o), .result_valid_o(result_valid_o),
    .rd_addr_o(rd_addr_o), .reg_wen_o(reg_wen_o)
  );

  always #(CLK_PERIOD / 2) clk = ~clk;

  function automatic logic [31:0] mkInst(input logic [2:0] f3, input logic [4:0] rd);
    return {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction

  // Reference results straight from the RV32M definitions using wide arithmetic.
  function automatic logic [31:0] refModel(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = $signed(a);
    ib = $signed(b);
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic bit isSpecial(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  task automatic applyStimulus(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input logic fl);
    inst_i    = inst;
    op1_i     = a;
    op2_i     = b;
    rd_addr_i = rd;
    flush_i   = fl;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nCmp++;
    assert (obs === expv) else begin
      nErr++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Called just after a rising edge; runs one op to completion and leaves a NOP on the inputs.
  task automatic runOp(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, output time tValid);
    logic [31:0] expv;
    int lat, holds, cyc;
    bit got;
    expv = refModel(f3, a, b);
    lat  = isSpecial(f3, a, b) ? 1 : 33;
    applyStimulus(mkInst(f3, rd), a, b, rd, 1'b0);
    holds = 0; cyc = 0; got = 0;
    while (!got && cyc <= 40) begin
      @(negedge clk);
      if (result_valid_o) got = 1;
      else begin
        holds += int'(hold_flag_o);
        cyc++;
        @(posedge clk); #1;
      end
    end
    tValid = $time;
    checkOutput({tag, "_valid_seen"}, {31'd0, got}, 32'd1);
    if (got) begin
      checkOutput({tag, "_result"}, result_o, expv);
      checkOutput({tag, "_rd"}, {27'd0, rd_addr_o}, {27'd0, rd});
      checkOutput({tag, "_wen"}, {31'd0, reg_wen_o}, 32'd1);
      checkOutput({tag, "_hold_done"}, {31'd0, hold_flag_o}, 32'd0);
      checkOutput({tag, "_latency"}, cyc, lat);
      checkOutput({tag, "_hold_cycles"}, holds, lat);
      @(posedge clk); #1;
    end
    applyStimulus(NOP_INST, 32'd0, 32'd0, 5'd0, 1'b0);
  endtask

  task automatic watchQuiet(input int n, output int valids, output int holds);
    valids = 0; holds = 0;
    repeat (n) begin
      @(negedge clk);
      valids += int'(result_valid_o);
      holds  += int'(hold_flag_o);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    time t0, t1;
    int v, h;
    logic [2:0]  rf3;
    logic [31:0] ra, rb;
    logic [4:0]  rrd;

    rst = 1'b1;
    applyStimulus(NOP_INST, 32'd0, 32'd0, 5'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_result", result_o, 32'd0);
    checkOutput("rst_valid", {31'd0, result_valid_o}, 32'd0);
    checkOutput("rst_wen", {31'd0, reg_wen_o}, 32'd0);
    checkOutput("rst_rd", {27'd0, rd_addr_o}, 32'd0);
    checkOutput("rst_hold", {31'd0, hold_flag_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    runOp("mul_7xm3", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, t0);
    @(negedge clk);
    checkOutput("valid_one_cycle", {31'd0, result_valid_o}, 32'd0);
    @(posedge clk); #1;
    runOp("mulhu_m1", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, t0);
    runOp("mulh_m1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, t0);
    runOp("mulhsu_m1", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, t0);
    runOp("mul_m1", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, t0);
    runOp("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd10, t0);
    runOp("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd11, t0);
    runOp("divu_100_7", 3'd5, 32'd100, 32'd7, 5'd12, t0);
    runOp("remu_100_7", 3'd7, 32'd100, 32'd7, 5'd13, t0);
    runOp("div_5_0", 3'd4, 32'd5, 32'd0, 5'd14, t0);
    runOp("rem_5_0", 3'd6, 32'd5, 32'd0, 5'd15, t0);
    runOp("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, t0);
    runOp("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, t0);

    // Reset while the divider is at iteration 10.
    applyStimulus(mkInst(3'd5, 5'd3), 32'd1000, 32'd7, 5'd3, 1'b0);
    repeat (11) begin @(posedge clk); #1; end
    @(negedge clk);
    checkOutput("rst_mid_busy", {31'd0, hold_flag_o}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    applyStimulus(NOP_INST, 32'd0, 32'd0, 5'd0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_hold", {31'd0, hold_flag_o}, 32'd0);
    checkOutput("rst_mid_result", result_o, 32'd0);
    watchQuiet(40, v, h);
    checkOutput("rst_mid_no_valid", v, 0);
    checkOutput("rst_mid_no_hold", h, 0);

    // Flush at iteration 5.
    applyStimulus(mkInst(3'd0, 5'd4), 32'd1234, 32'd5678, 5'd4, 1'b0);
    repeat (6) begin @(posedge clk); #1; end
    flush_i = 1'b1;
    @(negedge clk);
    checkOutput("flush_hold", {31'd0, hold_flag_o}, 32'd0);
    @(posedge clk); #1;
    applyStimulus(NOP_INST, 32'd0, 32'd0, 5'd0, 1'b0);
    watchQuiet(40, v, h);
    checkOutput("flush_no_valid", v, 0);
    checkOutput("flush_no_hold", h, 0);

    // Flush arriving together with a start.
    applyStimulus(mkInst(3'd5, 5'd9), 32'd50, 32'd3, 5'd9, 1'b1);
    @(negedge clk);
    checkOutput("flush_start_hold", {31'd0, hold_flag_o}, 32'd0);
    @(posedge clk); #1;
    applyStimulus(NOP_INST, 32'd0, 32'd0, 5'd0, 1'b0);
    watchQuiet(40, v, h);
    checkOutput("flush_start_no_valid", v, 0);
    checkOutput("flush_start_no_hold", h, 0);

    applyStimulus(ADD_INST, 32'd3, 32'd4, 5'd1, 1'b0);
    watchQuiet(8, v, h);
    checkOutput("add_no_hold", h, 0);
    checkOutput("add_no_valid", v, 0);
    applyStimulus(NOP_INST, 32'd0, 32'd0, 5'd0, 1'b0);
    watchQuiet(8, v, h);
    checkOutput("nop_no_hold", h, 0);
    checkOutput("nop_no_valid", v, 0);

    runOp("b2b_first", 3'd5, 32'd999, 32'd10, 5'd20, t0);
    runOp("b2b_second", 3'd5, 32'd12345, 32'd99, 5'd21, t1);
    checkOutput("b2b_gap", 32'((t1 - t0) / CLK_PERIOD), 32'd34);

    for (int i = 0; i < 16; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        default: ;
      endcase
      rrd = 5'($urandom_range(1, 31));
      runOp($sformatf("rand%0d_f%0d", i, rf3), rf3, ra, rb, rrd, t0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
